decompress_unit: RTL and testbench

Streaming decoder that rebuilds IEEE-754 single-precision words from the 2-bit class tag and 32-bit payload produced by `compress_unit`. It sits on the read-back path, after compressed words are fetched from storage and before the float consumer. It is a 2-stage registered pipeline with valid/ready handshakes on both sides, running at one word per cycle.

---
 rtl/decompress_unit.sv | 151 +++++++++++++++
 tb/tb_decompress_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_unit.sv
// Two-stage float32 decoder for compress_unit class tags, with valid/ready handshakes on both sides.
// Optional saturating reserved-tag counter is enabled by defining DECOMP_ERR_CNT_EN.
`timescale 1ns/1ps
module decompress_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  status,
  input  logic [31:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam int unsigned LAT      = 2;
  localparam int unsigned DW       = 32;
  localparam int unsigned QW       = 15;
  localparam int unsigned PW       = 4;
  localparam int unsigned MW       = 23;
  localparam int unsigned CW       = 16;
  localparam int unsigned EXP_BIAS = 113;

  localparam logic [1:0]    TAG_ZERO  = 2'b00;
  localparam logic [1:0]    TAG_SHORT = 2'b10;
  localparam logic [1:0]    TAG_RAW   = 2'b11;
  localparam logic [DW-1:0] QNAN      = 32'h7FC0_0000;

  // Stage-valid flags: bit 0 is stage 1, bit LAT-1 is stage 2.
  logic [LAT-1:0] r_vld;
  logic [1:0]     r_s1_tag;
  logic           r_s1_sign;
  logic           r_s1_qnz;
  logic [PW-1:0]  r_s1_p;
  logic [MW-1:0]  r_s1_mant;
  logic [DW-1:0]  r_s1_raw;
  logic [DW-1:0]  r_dout;
  logic           r_s2_err;
  logic           r_err;

  logic           w_s1_adv;
  logic           w_s2_adv;
  logic           w_acc;
  logic           w_take;
  logic [QW-1:0]  w_q;
  logic [MW-1:0]  w_qext;
  logic [PW-1:0]  w_p;
  logic           w_qnz;
  logic [MW-1:0]  w_mant;
  logic [DW-1:0]  w_word;
  logic           w_rsv;

  assign w_s2_adv = enable & (~r_vld[LAT-1] | out_ready);
  assign w_s1_adv = enable & (~r_vld[0] | w_s2_adv);
  assign in_ready = resetn & w_s1_adv;
  assign w_acc    = in_valid & in_ready;
  assign w_take   = r_vld[LAT-1] & out_ready & enable;

  assign w_q    = din[QW-1:0];
  assign w_qnz  = |w_q;
  assign w_qext = {8'b0, w_q};

  // Leading-one detector: the highest set bit wins.
  always_comb begin
    w_p = '0;
    for (int unsigned i = 0; i < QW; i++) begin
      if (w_q[4'(i)]) w_p = PW'(i);
    end
  end

  // Bits shifted past bit 22 (including the leading one) drop off, leaving the fraction.
  assign w_mant = w_qext << (5'(MW) - 5'(w_p));

  // Stage-2 word assembly from the stage-1 fields.
  always_comb begin
    w_word = '0;
    w_rsv  = 1'b0;
    case (r_s1_tag)
      TAG_ZERO:  w_word = '0;
      TAG_RAW:   w_word = r_s1_raw;
      TAG_SHORT: begin
        if (r_s1_qnz) w_word = {r_s1_sign, 8'(EXP_BIAS) + 8'(r_s1_p), r_s1_mant};
        else          w_word = {r_s1_sign, 31'b0};
      end
      default: begin
        w_word = QNAN;
        w_rsv  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld     <= '0;
      r_s1_tag  <= '0;
      r_s1_sign <= 1'b0;
      r_s1_qnz  <= 1'b0;
      r_s1_p    <= '0;
      r_s1_mant <= '0;
      r_s1_raw  <= '0;
      r_dout    <= '0;
      r_s2_err  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_take & r_s2_err;
      if (w_s2_adv) begin
        r_vld[LAT-1] <= r_vld[0];
        if (r_vld[0]) begin
          r_dout   <= w_word;
          r_s2_err <= w_rsv;
        end
      end
      if (w_s1_adv) begin
        r_vld[0] <= in_valid;
        if (w_acc) begin
          r_s1_tag  <= status;
          r_s1_sign <= din[QW];
          r_s1_qnz  <= w_qnz;
          r_s1_p    <= w_p;
          r_s1_mant <= w_mant;
          r_s1_raw  <= din;
        end
      end
    end
  end

`ifdef DECOMP_ERR_CNT_EN
  logic [CW-1:0] r_err_cnt;

  // Saturating count of reserved tags, stepping with each err pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= '0;
    end else if (w_take && r_s2_err && (r_err_cnt != {CW{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CW'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = CW'(0);
`endif

  assign out_valid = r_vld[LAT-1];
  assign dout      = r_dout;
  assign err       = r_err;

endmodule

// File: tb/tb_decompress_unit.sv
// Self-checking bench for decompress_unit: vector table, directed corner sequences and a
// randomized stream scored against an arithmetic decode model.
`timescale 1ns/1ps
module tb_decompress_unit;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  status;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        err;
  logic [15:0] err_cnt;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic        rsv;
    int          acc_cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] cur_exp = '0;
  logic        lat_chk = 1'b0;
  logic        nan_prev = 1'b0;
  int          exp_cnt = 0;

  decompress_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .status    (status),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value of the float the tag/payload pair denotes, from the decode rules.
  function automatic logic [31:0] ref_decode(input logic [1:0] st, input logic [31:0] d);
    int q;
    int p;
    logic [31:0] r;
    q = int'(d[14:0]);
    case (st)
      2'b00: r = 32'h0;
      2'b11: r = d;
      2'b01: r = QNAN;
      default: begin
        if (q == 0) r = {d[15], 31'h0};
        else begin
          p = 0;
          while ((1 << (p + 1)) <= q) p++;
          r = {d[15], 8'(113 + p), 23'((q - (1 << p)) << (23 - p))};
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: inputs accepted and outputs taken are observed mid-cycle.
  task automatic monitor();
    exp_t e;
    logic take;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
        nan_prev = 1'b0;
        exp_cnt  = 0;
      end else begin
        if (nan_prev && exp_cnt < 65535) exp_cnt++;
        check("err_pulse", 32'(err), 32'(nan_prev));
`ifdef DECOMP_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`else
        check("err_cnt", 32'(err_cnt), 32'd0);
`endif
        take     = out_valid & out_ready & enable;
        nan_prev = 1'b0;
        if (take) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h want no word", dout);
          end else begin
            e = sb.pop_front();
            check("dout", dout, e.exp);
            if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
            nan_prev = e.rsv;
          end
        end
        if (in_valid && in_ready) sb.push_back('{cur_exp, status == 2'b01, cyc});
      end
    end
  endtask

  task automatic send(input logic [1:0] st, input logic [31:0] d, input logic [31:0] exp);
    int n;
    logic acc;
    in_valid = 1'b1;
    status   = st;
    din      = d;
    cur_exp  = exp;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t        tbl[9];
  logic [31:0] bp[4];
  logic [31:0] hold;
  logic        sv_ov;
  logic [31:0] sv_do;
  logic        acc;
  int          n_acc;

  initial begin
    resetn    = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    status    = 2'b00;
    din       = 32'h0;
    fork
      monitor();
    join_none

    tbl[0] = '{2'b10, 32'h0000_4000, 32'h3F80_0000};
    tbl[1] = '{2'b10, 32'h0000_C000, 32'hBF80_0000};
    tbl[2] = '{2'b10, 32'h0000_2000, 32'h3F00_0000};
    tbl[3] = '{2'b10, 32'h0000_6000, 32'h3FC0_0000};
    tbl[4] = '{2'b10, 32'h0000_0001, 32'h3880_0000};
    tbl[5] = '{2'b00, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[6] = '{2'b11, 32'h4049_0FDB, 32'h4049_0FDB};
    tbl[7] = '{2'b10, 32'h0000_8000, 32'h8000_0000};
    tbl[8] = '{2'b10, 32'hFFFF_2000, 32'h3F00_0000};
    bp[0] = 32'h0000_1234;
    bp[1] = 32'h0000_8765;
    bp[2] = 32'h0000_0F0F;
    bp[3] = 32'h0000_7FFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Table vectors back-to-back, latency 2 each
    lat_chk = 1'b1;
    foreach (tbl[i]) send(tbl[i].st, tbl[i].d, tbl[i].exp);
    drain();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for 5 cycles while offering 4 words
    out_ready = 1'b0;
    n_acc = 0;
    hold  = '0;
    for (int c = 0; c < 5; c++) begin
      if (n_acc < 4) begin
        in_valid = 1'b1;
        status   = 2'b10;
        din      = bp[n_acc];
        cur_exp  = ref_decode(2'b10, bp[n_acc]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 2) begin
        check("bp_acc_count", 32'(n_acc), 32'd2);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold = dout;
      end
      if (c >= 2) check("bp_in_ready", 32'(in_ready), 32'd0);
      if (c > 2) check("bp_dout_stable", dout, hold);
      if (in_valid && in_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    while (n_acc < 4) begin
      send(2'b10, bp[n_acc], ref_decode(2'b10, bp[n_acc]));
      n_acc++;
    end
    drain();

    // Enable low for 3 cycles mid-stream
    send(2'b11, 32'h1111_2222, 32'h1111_2222);
    send(2'b10, 32'h0000_3C00, ref_decode(2'b10, 32'h0000_3C00));
    in_valid = 1'b1;
    status   = 2'b00;
    din      = 32'h5555_5555;
    cur_exp  = 32'h0;
    enable   = 1'b0;
    sv_ov = out_valid;
    sv_do = dout;
    check("en_ov_before", 32'(sv_ov), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("en_in_ready", 32'(in_ready), 32'd0);
      check("en_out_valid_hold", 32'(out_valid), 32'(sv_ov));
      check("en_dout_hold", dout, sv_do);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    send(2'b00, 32'h5555_5555, 32'h0);
    send(2'b10, 32'h0000_5000, ref_decode(2'b10, 32'h0000_5000));
    drain();

    // Reset with two words in flight
    out_ready = 1'b0;
    send(2'b10, 32'h0000_4000, 32'h3F80_0000);
    send(2'b01, 32'h0000_0000, QNAN);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_dout", dout, 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(2'b10, 32'h0000_A000, 32'hBF00_0000);
    drain();
    lat_chk = 1'b0;

    // Three reserved tags
    repeat (3) send(2'b01, 32'h0BAD_F00D, QNAN);
    drain();
    @(posedge clk);
    #1;
`ifdef DECOMP_ERR_CNT_EN
    check("rsv3_err_cnt", 32'(err_cnt), 32'd3);
`else
    check("rsv3_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Randomized stream with random backpressure and enable gaps
    for (int k = 0; k < 600; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        status   = 2'($urandom);
        din      = $urandom;
        cur_exp  = ref_decode(status, din);
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    drain();

`ifdef DECOMP_ERR_CNT_EN
    // Counter saturation: push past 0xFFFF reserved tags
    for (int k = 0; k < 65540; k++) send(2'b01, $urandom, QNAN);
    drain();
    @(posedge clk);
    #1;
    check("err_cnt_sat", 32'(err_cnt), 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
